// File: rtl/systolic_seq.sv
// Phase sequencer for an N x N weight-stationary systolic array: LOAD skews
// weights down the psum chain, COMPUTE paces skewed activations and flags results.
module systolic_seq #(
    parameter int N     = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_reuse_w,
    output logic [N-1:0]     wt_rd_en,
    output logic             en_weight_pass,
    output logic [N-1:0]     en_weight_capture,
    output logic [N-1:0]     act_rd_en,
    output logic [N-1:0]     out_valid,
    output logic             busy,
    output logic             done
);

    // Largest index is M+2N-2 with M = 2^LEN_W, so 2^LEN_W+2N-1 distinct values.
    localparam int CNT_W = $clog2((1 << LEN_W) + 2*N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] m1_q, m1_d;
    logic             hs;

    logic [N-1:0]     wt_d, cap_d, act_d, ov_d;
    logic             ewp_d, busy_d, done_d, rdy_d;
    int               t_i, m_i;

    always_comb begin
        hs      = cmd_valid && cmd_ready;
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        m1_d    = m1_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (hs) begin
                    m1_d    = cmd_len;
                    state_d = cmd_reuse_w ? COMPUTE : LOAD;
                end
            end
            LOAD: begin
                if (int'(cnt_q) == 2*N - 2) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end
            end
            COMPUTE: begin
                if (int'(cnt_q) == int'(m1_q) + 2*N - 1) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with cycle 0.
    always_comb begin
        t_i    = int'(cnt_d);
        m_i    = int'(m1_d) + 1;
        wt_d   = '0;
        cap_d  = '0;
        act_d  = '0;
        ov_d   = '0;
        ewp_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        rdy_d  = 1'b0;
        case (state_d)
            IDLE: rdy_d = 1'b1;
            LOAD: begin
                ewp_d  = 1'b1;
                busy_d = 1'b1;
                for (int c = 0; c < N; c++) begin
                    wt_d[c]  = (t_i >= c) && (t_i <= c + N - 1);
                    cap_d[c] = (t_i == N - 1 + c);
                end
            end
            COMPUTE: begin
                busy_d = 1'b1;
                for (int c = 0; c < N; c++) begin
                    act_d[c] = (t_i >= c) && (t_i <= c + m_i - 1);
                    ov_d[c]  = (t_i >= N + c) && (t_i <= N + c + m_i - 1);
                end
            end
            DONE:    done_d = 1'b1;
            default: rdy_d  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            cmd_ready         <= 1'b0;
            wt_rd_en          <= '0;
            en_weight_pass    <= 1'b0;
            en_weight_capture <= '0;
            act_rd_en         <= '0;
            out_valid         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            cmd_ready         <= rdy_d;
            wt_rd_en          <= wt_d;
            en_weight_pass    <= ewp_d;
            en_weight_capture <= cap_d;
            act_rd_en         <= act_d;
            out_valid         <= ov_d;
            busy              <= busy_d;
            done              <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        m1_q <= m1_d;
    end

endmodule

// File: tb/tb_systolic_seq.sv
// Scoreboard bench for systolic_seq: stimulus queues expected output snapshots,
// done cycles and out_valid bursts; a negedge monitor pops and compares them.
module tb_systolic_seq;

    localparam int N     = 4;
    localparam int LEN_W = 8;
    localparam int VW    = 4 + 4*N;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_reuse_w;
    logic [N-1:0]     wt_rd_en;
    logic             en_weight_pass;
    logic [N-1:0]     en_weight_capture;
    logic [N-1:0]     act_rd_en;
    logic [N-1:0]     out_valid;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    systolic_seq #(.N(N), .LEN_W(LEN_W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_len           (cmd_len),
        .cmd_reuse_w       (cmd_reuse_w),
        .wt_rd_en          (wt_rd_en),
        .en_weight_pass    (en_weight_pass),
        .en_weight_capture (en_weight_capture),
        .act_rd_en         (act_rd_en),
        .out_valid         (out_valid),
        .busy              (busy),
        .done              (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int cyc; logic [VW-1:0] val; } snap_t;
    typedef struct { int col; int start; int len; } burst_t;
    snap_t  snap_q[$];
    int     done_q[$];
    burst_t burst_q[$];

    logic [VW-1:0] rdy_vec;
    initial begin
        rdy_vec         = '0;
        rdy_vec[VW-1]   = 1'b1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack_out();
        return {cmd_ready, busy, done, en_weight_pass, wt_rd_en,
                en_weight_capture, act_rd_en, out_valid};
    endfunction

    // Expected outputs d cycles after the handshake edge, from the phase timeline.
    function automatic logic [VW-1:0] model(int d, int m, bit reuse);
        int L;
        int t;
        logic [N-1:0] wt, cap, act, ov;
        logic ewp, bsy, dn, rdy;
        L = reuse ? 0 : 2*N - 1;
        wt = '0; cap = '0; act = '0; ov = '0;
        ewp = 0; bsy = 0; dn = 0; rdy = 0;
        if (d >= 1 && d <= L) begin
            t = d - 1; ewp = 1; bsy = 1;
            for (int c = 0; c < N; c++) begin
                wt[c]  = (t >= c) && (t <= c + N - 1);
                cap[c] = (t == N - 1 + c);
            end
        end else if (d > L && d <= L + m + 2*N - 1) begin
            t = d - L - 1; bsy = 1;
            for (int c = 0; c < N; c++) begin
                act[c] = (t >= c) && (t <= c + m - 1);
                ov[c]  = (t >= N + c) && (t <= N + c + m - 1);
            end
        end else if (d == L + m + 2*N) begin
            dn = 1;
        end else begin
            rdy = 1;
        end
        return {rdy, bsy, dn, ewp, wt, cap, act, ov};
    endfunction

    task automatic push_cmd(input int T, input int m, input bit reuse, input int exp_done);
        int L;
        snap_t  s;
        burst_t b;
        L = reuse ? 0 : 2*N - 1;
        for (int d = 1; d <= L + m + 2*N + 1; d++) begin
            s.cyc = T + d;
            s.val = model(d, m, reuse);
            snap_q.push_back(s);
        end
        done_q.push_back(exp_done);
        for (int c = 0; c < N; c++) begin
            b.col = c; b.start = T + L + 1 + N + c; b.len = m;
            burst_q.push_back(b);
        end
    endtask

    task automatic issue(input int len, input bit reuse, output int T);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check("wait_cmd_ready", 0, 1);
            T = -1;
            return;
        end
        cmd_len     = LEN_W'(len);
        cmd_reuse_w = reuse;
        cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
        T           = cyc - 1;
        cmd_valid   = 1'b0;
        cmd_len     = LEN_W'($urandom);
        cmd_reuse_w = 1'b0;
    endtask

    // Monitor: snapshots, done pulses and per-column out_valid bursts.
    logic [N-1:0] prev_ov = '0;
    int           run_len[N];
    int           exp_len[N];
    snap_t        ms;
    burst_t       mb;
    int           md;

    always @(negedge clk) begin
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            ms = snap_q.pop_front();
            if (ms.cyc < cyc) check("snapshot_missed", cyc, ms.cyc);
            else              check("outputs", pack_out(), ms.val);
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) check("done_unexpected", 1, 0);
            else begin
                md = done_q.pop_front();
                check("done_cycle", cyc, md);
            end
        end
        for (int c = 0; c < N; c++) begin
            if (out_valid[c] === 1'b1 && !prev_ov[c]) begin
                run_len[c] = 1;
                if (burst_q.size() == 0) begin
                    check("out_valid_unexpected", c, 99);
                    exp_len[c] = 0;
                end else begin
                    mb = burst_q.pop_front();
                    check("out_valid_col", c, mb.col);
                    check("out_valid_start", cyc, mb.start);
                    exp_len[c] = mb.len;
                end
            end else if (out_valid[c] === 1'b1) begin
                run_len[c]++;
            end else if (prev_ov[c]) begin
                check("out_valid_len", run_len[c], exp_len[c]);
            end
            prev_ov[c] = (out_valid[c] === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int T;
        int nhs;
        int budget;
        logic rdy_b;
        logic [LEN_W-1:0] len_b;

        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_len     = '0;
        cmd_reuse_w = 1'b0;
        repeat (2) @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", pack_out(), '0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", pack_out(), rdy_vec);

        // M=3 with LOAD
        issue(2, 0, T);
        if (T >= 0) push_cmd(T, 3, 0, T + 18);

        // M=1 reusing weights
        issue(0, 1, T);
        if (T >= 0) push_cmd(T, 1, 1, T + 9);

        // M=256: counter must not wrap
        issue(255, 0, T);
        if (T >= 0) push_cmd(T, 256, 0, T + 271);

        // reset pulse at LOAD t=3
        issue(1, 0, T);
        if (T >= 0) begin
            push_cmd(T, 2, 0, T + 17);
            while (cyc < T + 4) begin
                @(posedge clk);
                #1;
            end
            reset_n = 1'b0;
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            snap_q.delete();
            done_q.delete();
            burst_q.delete();
            snap_q.push_back('{cyc: T + 5, val: '0});
            snap_q.push_back('{cyc: T + 6, val: rdy_vec});
        end

        // full LOAD after the aborted one
        issue(3, 0, T);
        if (T >= 0) push_cmd(T, 4, 0, T + 19);

        // cmd_valid held with cmd_len changing every cycle
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_reuse_w = 1'b0;
        cmd_len     = LEN_W'($urandom_range(0, 5));
        nhs    = 0;
        budget = 0;
        while (nhs < 2 && budget < 400) begin
            @(negedge clk);
            rdy_b = cmd_ready;
            len_b = cmd_len;
            @(posedge clk);
            #1;
            budget++;
            if (rdy_b) begin
                nhs++;
                T = cyc - 1;
                push_cmd(T, int'(len_b) + 1, 0, T + int'(len_b) + 1 + 15);
                if (nhs == 2) cmd_valid = 1'b0;
            end
            cmd_len = LEN_W'($urandom_range(0, 5));
        end
        cmd_valid = 1'b0;
        check("held_acceptances", nhs, 2);

        budget = 0;
        while (snap_q.size() > 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        check("snapshots_drained", snap_q.size(), 0);
        check("done_drained", done_q.size(), 0);
        check("bursts_drained", burst_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
